seven_seg_mux: RTL and testbench

Parametrised, memory-mapped driver for a multiplexed common-anode/cathode seven-segment display bank on the FPGA board. Software writes per-digit registers over a simple bus: raw segments or a hex nibble, decimal point and blank flags. A global control register adds enable and PWM brightness. The block time-multiplexes digits from a single clock using one-cycle scan enables (no derived clocks) and drives registered anode/segment outputs.

---
 rtl/seven_seg_mux.sv | 144 ++++++++++++++
 tb/tb_seven_seg_mux.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// Memory-mapped driver for a multiplexed seven-segment display bank.
// Per-digit registers plus a CTRL register (enable, PWM brightness); one-cycle scan enables.
module seven_seg_mux #(
  parameter int unsigned DIGITS           = 8,
  parameter int unsigned DIV_WIDTH        = 10,
  parameter int unsigned PWM_WIDTH        = 3,
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ANODE_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW   = 1,
  parameter int unsigned ADDR_LEN         = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [XLEN-1:0]     wdata,
  output logic [XLEN-1:0]     rdata,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int unsigned SEL_W  = $clog2(DIGITS);
  localparam int unsigned DIG_W  = 10;
  localparam int unsigned CTRL_W = PWM_WIDTH + 1;

  localparam logic AN_OFF  = (ANODE_ACTIVE_LOW != 0);
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);

  localparam logic [CTRL_W-1:0] CTRL_RST = {{PWM_WIDTH{1'b1}}, 1'b0};

  logic [DIV_WIDTH-1:0] cnt;
  logic [SEL_W-1:0]     sel;
  logic [DIG_W-1:0]     digit_q [DIGITS];
  logic [CTRL_W-1:0]    ctrl_q;

  logic                 scan_tick_c;
  logic [PWM_WIDTH-1:0] phase_c;
  logic [PWM_WIDTH-1:0] bright_c;
  logic [DIG_W-1:0]     cur_digit_c;
  logic [6:0]           pattern_c;
  logic [DIGITS-1:0]    one_hot_c;
  logic                 lit_c;
  logic [XLEN-1:0]      rd_c;
  logic                 unused_c;

  assign unused_c = ^wdata[XLEN-1:DIG_W];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign scan_tick_c = &cnt;
  assign phase_c     = cnt[DIV_WIDTH-1 -: PWM_WIDTH];
  assign bright_c    = ctrl_q[PWM_WIDTH:1];
  assign one_hot_c   = DIGITS'(1) << sel;

  // Select the digit currently being scanned; loop keeps non-power-of-two banks in range.
  always_comb begin
    cur_digit_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SEL_W'(i)) cur_digit_c = digit_q[i];
    end
  end

  assign pattern_c = cur_digit_c[8] ? hex7(cur_digit_c[3:0]) : cur_digit_c[6:0];
  assign lit_c     = ctrl_q[0] & ~cur_digit_c[9] & (phase_c < bright_c);

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_c = '0;
    if (addr == ADDR_LEN'(DIGITS)) rd_c = XLEN'(ctrl_q);
    for (int i = 0; i < DIGITS; i++) begin
      if (addr == ADDR_LEN'(i)) rd_c = XLEN'(digit_q[i]);
    end
  end

  // Scan divider and digit select.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sel <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
      if (scan_tick_c) begin
        if (sel == SEL_W'(DIGITS - 1)) sel <= '0;
        else                           sel <= sel + SEL_W'(1);
      end
    end
  end

  // Register file writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
      ctrl_q <= CTRL_RST;
    end else if (we) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (addr == ADDR_LEN'(i)) digit_q[i] <= wdata[DIG_W-1:0];
      end
      if (addr == ADDR_LEN'(DIGITS)) ctrl_q <= wdata[CTRL_W-1:0];
    end
  end

  // Registered read port returns pre-write contents on a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= rd_c;
  end

  // Display outputs, registered from the current scan state.
  always_ff @(posedge clk) begin
    if (reset || !lit_c) begin
      anode <= {DIGITS{AN_OFF}};
      seg   <= {7{SEG_OFF}};
      dp    <= SEG_OFF;
    end else begin
      anode <= one_hot_c ^ {DIGITS{AN_OFF}};
      seg   <= pattern_c ^ {7{SEG_OFF}};
      dp    <= cur_digit_c[7] ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux: DIGITS=4, DIV_WIDTH=4, PWM_WIDTH=2, active-low outputs.
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_mux #(
    .DIGITS(4), .DIV_WIDTH(4), .PWM_WIDTH(2), .XLEN(32),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .anode(anode), .seg(seg), .dp(dp)
  );

  // Reference model: time since reset plus register contents.
  int          m = 0;
  logic [9:0]  mdig [4];
  logic [2:0]  mctrl = 3'b110;
  int          last_sel = 0;
  int          last_ph = 0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [31:0] exp_rd = '0;
  int          hex_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                                'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30) $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < 4)  return {22'd0, mdig[a]};
    if (a == 4) return {29'd0, mctrl};
    return 32'd0;
  endfunction

  // One clock: drive inputs, predict outputs after the edge, update model, compare.
  task automatic step(input logic w, input logic r, input int a, input logic [31:0] d,
                      input logic rs);
    int ph;
    int sl;
    logic [9:0] cur;
    logic [6:0] pat;
    logic lit;
    we = w; re = r; addr = 3'(a); wdata = d; reset = rs;
    ph = (m % 16) / 4;
    sl = (m / 16) % 4;
    if (rs) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_rd = '0;
      m = 0;
      for (int i = 0; i < 4; i++) mdig[i] = '0;
      mctrl = 3'b110;
    end else begin
      cur = mdig[sl];
      lit = mctrl[0] && !cur[9] && (ph < int'(mctrl[2:1]));
      pat = cur[8] ? 7'(hex_tab[cur[3:0]]) : cur[6:0];
      if (lit) begin
        exp_an = ~(4'b0001 << sl); exp_seg = ~pat; exp_dp = ~cur[7];
      end else begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      if (r) exp_rd = model_read(a);
      if (w) begin
        if (a < 4) mdig[a] = d[9:0];
        else if (a == 4) mctrl = d[2:0];
      end
      m++;
    end
    last_sel = sl; last_ph = ph;
    @(posedge clk); #1;
    chk("anode", 32'(anode), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("dp", 32'(dp), 32'(exp_dp));
    chk("rdata", rdata, exp_rd);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 32'd0, 1'b0);
  endtask

  task automatic advance_to(input int s, input int p);
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      idle();
      if (last_sel == s && last_ph == p) found = 1'b1;
    end
    chk("advance_timeout", 32'(found), 32'd1);
  endtask

  typedef struct {
    int          a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];
  int   lit_cnt;

  initial begin
    for (int i = 0; i < 4; i++) mdig[i] = '0;
    tbl[0] = '{0, 32'h0000_0103, 32'h103};
    tbl[1] = '{1, 32'hFFFF_F0FF, 32'h0FF};
    tbl[2] = '{2, 32'h0000_0200, 32'h200};
    tbl[3] = '{3, 32'h0000_0179, 32'h179};
    tbl[4] = '{5, 32'h0000_FFFF, 32'h0};
    tbl[5] = '{4, 32'hFFFF_FFF8, 32'h0};
    tbl[6] = '{6, 32'h0000_0001, 32'h0};
    tbl[7] = '{7, 32'h0000_03FF, 32'h0};
    tbl[8] = '{4, 32'h0000_000F, 32'h7};
    tbl[9] = '{4, 32'h0000_0007, 32'h7};

    // Reset and idle: everything dark, CTRL reads back B=3, enable=0.
    step(1'b0, 1'b0, 0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 0, 32'd0, 1'b1);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    for (int i = 0; i < 20; i++) idle();
    step(1'b0, 1'b1, 4, 32'd0, 1'b0);
    chk("ctrl_rst_read", rdata, 32'h6);

    // Register write/readback table.
    foreach (tbl[i]) begin
      step(1'b1, 1'b0, tbl[i].a, tbl[i].wd, 1'b0);
      step(1'b0, 1'b1, tbl[i].a, 32'd0, 1'b0);
      chk($sformatf("tbl%0d_read", i), rdata, tbl[i].exp);
    end
    step(1'b0, 1'b1, 0, 32'd0, 1'b0);
    chk("digit0_intact", rdata, 32'h103);
    step(1'b0, 1'b1, 1, 32'd0, 1'b0);
    chk("digit1_intact", rdata, 32'h0FF);

    // Per-slot display contents.
    advance_to(0, 0);
    chk("s0_anode", 32'(anode), 32'hE);
    chk("s0_seg", 32'(seg), 32'h30);
    advance_to(0, 3);
    chk("s0_ph3_dark", 32'(anode), 32'hF);
    advance_to(1, 1);
    chk("s1_anode", 32'(anode), 32'hD);
    chk("s1_seg", 32'(seg), 32'h00);
    chk("s1_dp", 32'(dp), 32'h0);
    advance_to(2, 0);
    chk("s2_blank", 32'(anode), 32'hF);
    advance_to(3, 2);
    chk("s3_anode", 32'(anode), 32'h7);
    chk("s3_seg", 32'(seg), 32'h10);
    chk("s3_dp", 32'(dp), 32'h1);
    advance_to(0, 0);
    chk("wrap_anode", 32'(anode), 32'hE);

    // Brightness extremes: B=0 dark, B=1 lit only in phase 0.
    step(1'b1, 1'b0, 4, 32'h1, 1'b0);
    idle();
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      idle();
      if (anode != 4'hF) lit_cnt++;
    end
    chk("b0_lit_count", 32'(lit_cnt), 32'd0);
    step(1'b1, 1'b0, 4, 32'h3, 1'b0);
    idle();
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      idle();
      if (anode != 4'hF) lit_cnt++;
    end
    chk("b1_lit_count", 32'(lit_cnt), 32'd12);

    // Same-cycle write and read.
    step(1'b1, 1'b1, 0, 32'h0AA, 1'b0);
    chk("wr_rd_old", rdata, 32'h103);
    step(1'b0, 1'b1, 0, 32'd0, 1'b0);
    chk("wr_rd_new", rdata, 32'h0AA);

    // Reset mid-scan.
    step(1'b1, 1'b0, 4, 32'h7, 1'b0);
    advance_to(2, 1);
    step(1'b0, 1'b0, 0, 32'd0, 1'b1);
    chk("midrst_anode", 32'(anode), 32'hF);
    chk("midrst_rdata", rdata, 32'h0);
    step(1'b0, 1'b1, 4, 32'd0, 1'b0);
    chk("midrst_ctrl", rdata, 32'h6);
    step(1'b0, 1'b1, 0, 32'd0, 1'b0);
    chk("midrst_digit0", rdata, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic w;
      logic r;
      logic rs;
      int   a;
      logic [31:0] d;
      w  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 1) == 0);
      rs = ($urandom_range(0, 499) == 0);
      a  = $urandom_range(0, 7);
      d  = $urandom;
      if (a == 4 && $urandom_range(0, 1) == 0) d[0] = 1'b1;
      step(w, r, a, d, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
